// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the multiply/divide unit.
//   start  request strobe, sampled on the rising edge
//   op     3-bit operation code
//   A, B   operands (rs / rt)
//   busy   a mult/div is in flight
//   hi, lo architectural HI/LO registers
// master = EX-stage / hazard side, slave = mdu_unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, input  busy, hi, lo);
  modport slave  (input  start, op, A, B, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (clears busy, HI, LO, counter)
//   bus      mdu_if slave: start/op/A/B in, busy/hi/lo out
// The result is computed combinationally at the accept edge and parked in
// pending registers; HI/LO are only updated on the edge busy falls, so an
// operation discarded by reset never reaches architectural state.
// op: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, else no-op.
module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic  clk,
  input  logic  reset_n,
  mdu_if.slave  bus
);
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  // Multiply: sign- or zero-extend to 2*WIDTH, then a plain truncated product
  // is the correct two's-complement result in both cases.
  logic [2*WIDTH-1:0] mul_s, mul_u;
  assign mul_s = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
  assign mul_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

  // Signed divide via magnitudes. The most-negative dividend has magnitude
  // 2^(WIDTH-1) as an unsigned value, so MIN / -1 naturally wraps to MIN, rem 0.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_abs, b_abs, b_safe_s, b_safe_u;
  logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  assign a_neg    = bus.A[WIDTH-1];
  assign b_neg    = bus.B[WIDTH-1];
  assign b_zero   = (bus.B == '0);
  assign a_abs    = a_neg ? -bus.A : bus.A;
  assign b_abs    = b_neg ? -bus.B : bus.B;
  // Divisor forced non-zero so the dividers never see /0; the /0 result is overridden below.
  assign b_safe_s = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_abs;
  assign b_safe_u = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.B;
  assign q_mag    = a_abs / b_safe_s;
  assign r_mag    = a_abs % b_safe_s;
  assign q_s      = b_zero ? '1    : ((a_neg ^ b_neg) ? -q_mag : q_mag);
  assign r_s      = b_zero ? bus.A : (a_neg ? -r_mag : r_mag);
  assign q_u      = b_zero ? '1    : bus.A / b_safe_u;
  assign r_u      = b_zero ? bus.A : bus.A % b_safe_u;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        unique case (bus.op)
          3'b000: begin
            {pend_hi_d, pend_lo_d} = mul_s;
            cnt_d = CNT_W'(MUL_CYCLES - 1); state_d = RUN;
          end
          3'b001: begin
            {pend_hi_d, pend_lo_d} = mul_u;
            cnt_d = CNT_W'(MUL_CYCLES - 1); state_d = RUN;
          end
          3'b010: begin
            pend_hi_d = r_s; pend_lo_d = q_s;
            cnt_d = CNT_W'(DIV_CYCLES - 1); state_d = RUN;
          end
          3'b011: begin
            pend_hi_d = r_u; pend_lo_d = q_u;
            cnt_d = CNT_W'(DIV_CYCLES - 1); state_d = RUN;
          end
          3'b100:  hi_d = bus.A;
          3'b101:  lo_d = bus.A;
          default: ;
        endcase
      end
      RUN: begin
        // Requests while running are dropped entirely; the hazard unit holds them.
        if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: self-checking bench for mdu_unit (WIDTH=32, 5/10 cycles).
// Directed scenarios plus randomized ops checked against a 64-bit arithmetic
// reference model and a model of the HI/LO registers.
module tb_mdu_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_unit #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  function automatic void ref_calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p = 0; q = 0; r = 0;
    h = '0; l = '0;
    case (op)
      3'd0: begin p = sa * sb; {h, l} = p; end
      3'd1: begin p = ua * ub; {h, l} = p; end
      default: begin
        if (b == '0) begin
          l = '1; h = a;
        end else begin
          if (op == 3'd2) begin q = sa / sb; r = sa - sb * q; end
          else            begin q = ua / ub; r = ua - ub * q; end
          l = q[31:0]; h = r[31:0];
        end
      end
    endcase
  endfunction

  // Issue a mult/div at a negedge with the unit idle; during busy, drive
  // garbage (random start/op/A/B), or an mthi 0x1234 on busy cycle 'intrude'.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int intrude);
    int n;
    logic [W-1:0] h, l;
    ref_calc(op, a, b, h, l);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    n = 0;
    while (bus.busy === 1'b1 && n < 60) begin
      n++;
      chk({tag, "_hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
      if (intrude > 0) begin
        bus.start = (n == intrude); bus.op = 3'd4; bus.A = 32'h1234; bus.B = $urandom;
      end else begin
        bus.start = 1'($urandom_range(0, 1)); bus.op = 3'($urandom); bus.A = $urandom; bus.B = $urandom;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'((op < 3'd2) ? MC : DC));
    exp_hi = h; exp_lo = l;
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
  endtask

  // Single-cycle ops (mthi/mtlo/no-op), issued at a negedge with the unit idle.
  task automatic run_mv(input string tag, input logic [2:0] op, input logic [W-1:0] a);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = $urandom;
    @(negedge clk);
    bus.start = 1'b0; bus.A = $urandom;
    if (op == 3'd4) exp_hi = a;
    if (op == 3'd5) exp_lo = a;
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] tbl [5];
    tbl[0] = 32'h0; tbl[1] = 32'h1; tbl[2] = 32'hFFFF_FFFF; tbl[3] = 32'h8000_0000; tbl[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.A = '0; bus.B = '0;
    #12;
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_hilo", {bus.hi, bus.lo}, 64'(0));
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    run_md("mult_neg",  3'd0, 32'hFFFF_FFFF, 32'd2, 0);
    chk("mult_neg_val", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_md("multu",     3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    chk("multu_val", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
    run_md("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg_val", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md("divu",      3'd3, 32'd7, 32'd2, 0);
    chk("divu_val", {bus.hi, bus.lo}, {32'd1, 32'd3});
    run_md("div_zero",  3'd2, 32'd5, 32'd0, 0);
    chk("div_zero_val", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});
    run_md("divu_zero", 3'd3, 32'hDEAD_BEEF, 32'd0, 0);
    chk("divu_zero_val", {bus.hi, bus.lo}, {32'hDEAD_BEEF, 32'hFFFF_FFFF});
    run_md("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf_val", {bus.hi, bus.lo}, {32'h0, 32'h8000_0000});
    run_md("mult_min",  3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    chk("mult_min_val", {bus.hi, bus.lo}, {32'h4000_0000, 32'h0});

    run_md("div_block", 3'd2, 32'd100, 32'd3, 3);
    chk("div_block_val", {bus.hi, bus.lo}, {32'd1, 32'd33});
    @(negedge clk);
    run_mv("mthi", 3'd4, 32'h1234);
    chk("mthi_val", {bus.hi, bus.lo}, {32'h1234, 32'd33});
    run_mv("mtlo", 3'd5, 32'hCAFE);
    run_mv("noop", 3'd6, 32'h5555);

    // Back-to-back: divu issued in the first idle cycle after the mult.
    run_md("b2b_mult", 3'd0, 32'd6, 32'd7, 0);
    chk("b2b_mult_val", {bus.hi, bus.lo}, {32'd0, 32'd42});
    run_md("b2b_divu", 3'd3, 32'd9, 32'd4, 0);
    chk("b2b_divu_val", {bus.hi, bus.lo}, {32'd1, 32'd2});

    // Reset in the middle of a mult: HI/LO clear and never get the product.
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    chk("rst_mid_busy", 64'(bus.busy), 64'(0));
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'(0));
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_after", {31'h0, bus.busy, bus.hi, bus.lo}, 64'(0));
    end

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op < 3'd4) run_md("rnd_md", op, pick(), pick(), 0);
      else           run_mv("rnd_mv", op, pick());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
